// File: rtl/irq_ctrl.sv
// irq_ctrl: nested, prioritised interrupt controller that synchronises requests, arbitrates by level and redirects the pipeline.
// All outputs registered; redirect one cycle after pipe_safe in ARM, and a pending eret return always wins over a take.
module irq_ctrl #(
  parameter int          NUM_IRQ     = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0040
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_din,
  input  logic               pipe_safe,
  input  logic [31:0]        epc_in,
  input  logic               eret,
  output logic               redirect,
  output logic [31:0]        new_pc,
  output logic [NUM_IRQ-1:0] cause,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] mask
);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, ARM, TAKE, HOLD} state_t;
  state_t state;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] rise;
  logic [31:0]        epc_q [NUM_IRQ];

  logic               win_vld, top_vld, nxt_vld;
  logic [IW-1:0]      win_idx, top_idx, nxt_idx;
  logic [NUM_IRQ-1:0] win_oh, top_oh, nxt_oh;
  logic               take_go, ret_go;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // top = current nesting level, nxt = the level uncovered when top returns
  always_comb begin
    top_vld = 1'b0;
    top_idx = '0;
    nxt_vld = 1'b0;
    nxt_idx = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (in_service[i]) begin
        top_vld = 1'b1;
        top_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (in_service[i] && (IW'(i) != top_idx)) begin
        nxt_vld = 1'b1;
        nxt_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && mask[i] && (!top_vld || (IW'(i) > top_idx))) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end

  assign win_oh  = win_vld ? (NUM_IRQ'(1) << win_idx) : '0;
  assign top_oh  = top_vld ? (NUM_IRQ'(1) << top_idx) : '0;
  assign nxt_oh  = nxt_vld ? (NUM_IRQ'(1) << nxt_idx) : '0;
  assign take_go = (state == ARM) && win_vld && pipe_safe && !eret;
  assign ret_go  = eret && top_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < NUM_IRQ; i++) epc_q[i] <= '0;
      prev_q     <= '0;
      pending    <= '0;
      in_service <= '0;
      cause      <= '0;
      mask       <= '1;
      redirect   <= 1'b0;
      new_pc     <= '0;
      state      <= IDLE;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_q[SYNC_STAGES-1];

      if (mask_we) mask <= mask_din;

      // a fresh edge in the take cycle re-arms the source just taken
      pending  <= (pending & ~(take_go ? win_oh : '0)) | rise;
      redirect <= take_go | ret_go;

      if (ret_go) begin
        new_pc     <= epc_q[top_idx];
        in_service <= in_service & ~top_oh;
        cause      <= nxt_oh;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: if (win_vld) state <= ARM;
          ARM: begin
            if (!win_vld) begin
              state <= IDLE;
            end else if (take_go) begin
              new_pc         <= VEC_BASE + VEC_STRIDE * 32'(win_idx);
              epc_q[win_idx] <= epc_in;
              in_service     <= in_service | win_oh;
              cause          <= win_oh;
              state          <= TAKE;
            end
          end
          TAKE:    state <= HOLD;
          HOLD:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, plus a per-cycle model built on a nesting stack.
module tb_irq_ctrl;
  localparam int          N  = 3;
  localparam int          S  = 2;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'h0000_0040;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_din = '0;
  logic          pipe_safe = 1'b0;
  logic [31:0]   epc_in = '0;
  logic          eret = 1'b0;
  logic          redirect;
  logic [31:0]   new_pc;
  logic [N-1:0]  cause, pending, in_service, mask;

  int total = 0;
  int bad = 0;

  irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_din(mask_din),
    .pipe_safe(pipe_safe), .epc_in(epc_in), .eret(eret), .redirect(redirect), .new_pc(new_pc),
    .cause(cause), .pending(pending), .in_service(in_service), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: nesting kept as a stack of {level, return pc}; phase 0 idle, 1 armed, 2 taken, 3 settling
  typedef struct {int idx; logic [31:0] pc;} lvl_t;
  lvl_t         stk[$];
  logic [N-1:0] hist[$];
  int           phase = 0;
  logic         m_redirect = 1'b0;
  logic [31:0]  m_pc = '0;
  logic [N-1:0] m_cause = '0, m_pend = '0, m_mask = '1;

  function automatic logic [N-1:0] stk_bits();
    logic [N-1:0] b = '0;
    foreach (stk[k]) b[stk[k].idx] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk.delete();
      hist.delete();
      for (int k = 0; k <= S; k++) hist.push_back('0);
      phase = 0; m_redirect = 1'b0; m_pc = '0; m_cause = '0; m_pend = '0; m_mask = '1;
    end else begin
      logic [N-1:0] rise;
      int top, win;
      rise = hist[1] & ~hist[0];
      top = (stk.size() > 0) ? stk[stk.size()-1].idx : -1;
      win = -1;
      for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i] && i > top) win = i;
      m_redirect = 1'b0;
      if (eret && stk.size() > 0) begin
        m_redirect = 1'b1;
        m_pc = stk[stk.size()-1].pc;
        stk.delete(stk.size()-1);
        m_cause = (stk.size() > 0) ? (N'(1) << stk[stk.size()-1].idx) : '0;
        phase = 0;
      end else begin
        case (phase)
          0: if (win >= 0) phase = 1;
          1: begin
            if (win < 0) phase = 0;
            else if (pipe_safe && !eret) begin
              m_redirect = 1'b1;
              m_pc = VB + VS * 32'(win);
              stk.push_back('{win, epc_in});
              m_pend[win] = 1'b0;
              m_cause = N'(1) << win;
              phase = 2;
            end
          end
          2: phase = 3;
          default: phase = 0;
        endcase
      end
      m_pend = m_pend | rise;
      if (mask_we) m_mask = mask_din;
      void'(hist.pop_front());
      hist.push_back(irq_in);
    end
  end

  always @(negedge clk) begin
    chk("redirect", redirect, m_redirect);
    if (m_redirect) chk("new_pc", new_pc, m_pc);
    chk("pending", pending, m_pend);
    chk("in_service", in_service, stk_bits());
    chk("cause", cause, m_cause);
    chk("mask", mask, m_mask);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_redirect(input string nm, input logic [31:0] exp, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!redirect && n < 40);
    chk({nm, "_seen"}, redirect, 1);
    chk({nm, "_pc"}, new_pc, exp);
  endtask

  task automatic do_eret(input string nm, input logic [31:0] exp);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    chk({nm, "_seen"}, redirect, 1);
    chk({nm, "_pc"}, new_pc, exp);
  endtask

  initial begin
    int n;
    int cnt;
    cyc(3);
    chk("rst_mask", mask, 3'b111);
    chk("rst_redirect", redirect, 0);
    chk("rst_pending", pending, 0);
    chk("rst_in_service", in_service, 0);
    rst_n = 1'b1;

    // single take
    irq_in = 3'b010; pipe_safe = 1'b1; epc_in = 32'h24;
    cyc(3);
    chk("t1_pending", pending, 3'b010);
    wait_redirect("t1_take", 32'h140, n);
    chk("t1_in_service", in_service, 3'b010);
    chk("t1_cause", cause, 3'b010);

    // nesting and unwinding
    irq_in = 3'b110; epc_in = 32'h148;
    wait_redirect("t2_take", 32'h180, n);
    chk("t2_in_service", in_service, 3'b110);
    do_eret("t2_ret1", 32'h148);
    chk("t2_in_service1", in_service, 3'b010);
    chk("t2_cause1", cause, 3'b010);
    do_eret("t2_ret2", 32'h24);
    chk("t2_in_service2", in_service, 3'b000);
    irq_in = '0;
    cyc(4);

    // lower priority waits for the return
    irq_in = 3'b100; epc_in = 32'h200;
    wait_redirect("t3_take", 32'h180, n);
    cyc(2);
    irq_in = 3'b101;
    cyc(8);
    chk("t3_pending", pending, 3'b001);
    chk("t3_no_take", redirect, 0);
    chk("t3_in_service", in_service, 3'b100);
    do_eret("t3_ret", 32'h200);
    wait_redirect("t3_take0", 32'h100, n);
    chk("t3_gap", n, 2);
    do_eret("t3_ret0", 32'h200);
    irq_in = '0;
    cyc(4);

    // mask holds a request until re-enabled
    mask_we = 1'b1; mask_din = 3'b110;
    cyc(1);
    mask_we = 1'b0;
    chk("t4_mask", mask, 3'b110);
    irq_in = 3'b001; epc_in = 32'h300;
    cyc(8);
    chk("t4_pending", pending, 3'b001);
    chk("t4_no_take", redirect, 0);
    mask_we = 1'b1; mask_din = 3'b111;
    cyc(1);
    mask_we = 1'b0;
    wait_redirect("t4_take", 32'h100, n);
    do_eret("t4_ret", 32'h300);
    irq_in = '0;
    cyc(4);

    // pipe_safe gating, eret beats a take
    irq_in = 3'b001;
    wait_redirect("t5_take0", 32'h100, n);
    pipe_safe = 1'b0;
    cyc(2);
    irq_in = 3'b011;
    cyc(10);
    chk("t5_pending", pending, 3'b010);
    chk("t5_in_service", in_service, 3'b001);
    pipe_safe = 1'b1;
    do_eret("t5_ret_wins", 32'h300);
    chk("t5_in_service_ret", in_service, 3'b000);
    wait_redirect("t5_take1", 32'h140, n);
    chk("t5_gap", n, 2);
    do_eret("t5_ret1", 32'h300);
    irq_in = '0;
    cyc(4);
    pipe_safe = 1'b0;
    irq_in = 3'b100;
    cyc(10);
    pipe_safe = 1'b1;
    @(negedge clk);
    chk("t5_lat_seen", redirect, 1);
    chk("t5_lat_pc", new_pc, 32'h180);
    do_eret("t5_ret2", 32'h300);
    irq_in = '0;
    cyc(4);

    // reset in the middle of a nest
    mask_we = 1'b1; mask_din = 3'b011;
    cyc(1);
    mask_we = 1'b0;
    irq_in = 3'b001; epc_in = 32'h400;
    wait_redirect("t6_take0", 32'h100, n);
    irq_in = 3'b011; epc_in = 32'h404;
    wait_redirect("t6_take1", 32'h140, n);
    chk("t6_in_service", in_service, 3'b011);
    cyc(2);
    #2;
    rst_n = 1'b0;
    irq_in = '0;
    #1;
    chk("t6_rst_in_service", in_service, 0);
    chk("t6_rst_mask", mask, 3'b111);
    chk("t6_rst_redirect", redirect, 0);
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_cause", cause, 0);
    cyc(2);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (redirect) cnt++;
    end
    chk("t6_no_redirect_after_release", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
